dmem_seq: RTL and testbench

- Sequences every load/store from the LSU onto a single-port, word-wide, synchronous-read data RAM.
- Performs byte-lane alignment for loads, with sign- or zero-extension.
- Performs read-modify-write for SB/SH so that the RAM needs no byte enables.
- Detects misaligned accesses and reports them without touching memory. Sits between the EX/MEM stage and the data RAM.

---
 rtl/dmem_seq.sv | 183 ++++++++++++++++++
 tb/tb_dmem_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_seq.sv
// dmem_seq: sequences LSU loads/stores onto a single-port, synchronous-read,
// word-wide data RAM. Loads are lane-aligned and extended. Byte and half
// stores are done as read-modify-write, so the RAM needs no byte enables.
// Misaligned requests are answered with resp_err and never reach the RAM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; the only state with req_ready=1
// S_READ  | RAM read strobe for a load, or the read half of SB/SH
// S_WAIT  | RAM data returns; extend it for loads, merge it for SB/SH
// S_WRITE | RAM write strobe for SW, or the merged word for SB/SH
// S_RESP  | response held until resp_ready
module dmem_seq #(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_ctrl,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic            mem_en,
    output logic            mem_we,
    output logic [SIZE-3:0] mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        misalign;
    logic        ctrl_is_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Address bits above the RAM window are ignored by design.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:SIZE];

    assign accept     = req_valid && (state == S_IDLE);
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_en     = (state == S_READ) || (state == S_WRITE);
    assign mem_we     = (state == S_WRITE);

    // Alignment check on the incoming request.
    always_comb begin
        misalign = 1'b0;
        case (req_ctrl)
            OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
            OP_LW, OP_SW:         misalign = (req_addr[1:0] != 2'b00);
            default:              misalign = 1'b0;
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (misalign)
                        state_nxt = S_RESP;
                    else if (req_ctrl == OP_SW)
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = ctrl_is_store ? S_WRITE : S_RESP;
            S_WRITE: state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ctrl_is_store = (ctrl_q == OP_SB) || (ctrl_q == OP_SH);

    // Lane select and extension of the returned RAM word.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = 32'h0;
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ctrl_q)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LW:   load_data = mem_rdata;
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    // Splice store data into the word just read for SB/SH.
    always_comb begin
        merged = mem_rdata;
        if (ctrl_q == OP_SB) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (ctrl_q == OP_SH) begin
            if (off_q[1])
                merged[31:16] = wdata_q;
            else
                merged[15:0] = wdata_q;
        end
    end

    // State register, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ctrl_q     <= OP_LB;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ctrl_q     <= req_ctrl;
                off_q      <= req_addr[1:0];
                wdata_q    <= req_wdata[15:0];
                resp_err   <= misalign;
                resp_rdata <= 32'h0;
                // Error responses leave the RAM-side address untouched.
                if (!misalign)
                    mem_addr <= req_addr[SIZE-1:2];
                // SW goes straight to WRITE, so its data is loaded here.
                if (!misalign && req_ctrl == OP_SW)
                    mem_wdata <= req_wdata;
            end
            if (state == S_WAIT) begin
                if (ctrl_is_store)
                    mem_wdata <= merged;
                else
                    resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_seq.sv
// tb_dmem_seq: directed bench for dmem_seq with a behavioural synchronous
// RAM and a bus monitor counting RAM strobes and accepted requests.
module tb_dmem_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:1023];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          acc_cnt = 0;
    int          illegal_cnt = 0;
    logic [9:0]  last_wa = '0;
    logic [31:0] last_wd = '0;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011;
    localparam logic [2:0] LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    dmem_seq #(.SIZE(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ctrl   (req_ctrl),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Bus monitor: counts strobes/accepts and flags strobes in wrong states.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_en && mem_we) begin
                wr_cnt  = wr_cnt + 1;
                last_wa = mem_addr;
                last_wd = mem_wdata;
            end
            if (mem_en && !mem_we) rd_cnt = rd_cnt + 1;
            if (req_valid && req_ready) acc_cnt = acc_cnt + 1;
            if (mem_en && (req_ready || resp_valid)) illegal_cnt = illegal_cnt + 1;
            if (mem_we && !mem_en) illegal_cnt = illegal_cnt + 1;
        end
    end

    // One complete transaction with resp_ready=1; lat=0 means no response.
    task automatic do_req(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e);
        bit done;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = c; req_addr = a; req_wdata = wd; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rd = 'x; e = 'x; done = 0;
        for (int i = 1; i <= 20 && !done; i++) begin
            if (resp_valid) begin
                lat = i; rd = resp_rdata; e = resp_err; done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (done) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_ctrl = 3'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if ({resp_valid, resp_err, mem_en, mem_we} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got=%b exp=0000", {resp_valid, resp_err, mem_en, mem_we}); end
        checks++; if (resp_rdata !== 32'h0 || mem_wdata !== 32'h0 || mem_addr !== 10'h0) begin errors++; $display("FAIL reset_data rdata=%h wdata=%h addr=%h exp=0", resp_rdata, mem_wdata, mem_addr); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_sw();
        int lat; logic [31:0] rd; logic e; int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(SW, 32'h0000_0008, 32'hDEAD_BEEF, lat, rd, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp err=%b rdata=%h exp=0/0", e, rd); end
        checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL sw_strobes wr=%0d rd=%0d exp=1/0", wr_cnt - w0, rd_cnt - r0); end
        checks++; if (last_wa !== 10'd2 || last_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_write addr=%0d data=%h exp=2/deadbeef", last_wa, last_wd); end
    endtask

    task automatic test_loads();
        logic [2:0]  c [8]  = '{LB, LBU, LH, LHU, LW, LB, LH, LW};
        logic [31:0] a [8]  = '{32'h00B, 32'h00B, 32'h00A, 32'h008, 32'h008, 32'h008, 32'h008, 32'hFFFF_F008};
        logic [31:0] ex [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                32'h80FF_7F01, 32'h0000_0001, 32'h0000_7F01, 32'h80FF_7F01};
        int lat; logic [31:0] rd; logic e; int w0;
        ram[2] = 32'h80FF_7F01;
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            do_req(c[i], a[i], 32'hFFFF_FFFF, lat, rd, e);
            checks++; if (rd !== ex[i] || e !== 1'b0) begin errors++; $display("FAIL load%0d_data got=%h err=%b exp=%h", i, rd, e, ex[i]); end
            checks++; if (lat !== 3) begin errors++; $display("FAIL load%0d_latency got=%0d exp=3", i, lat); end
        end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL load_no_write got=%0d exp=0", wr_cnt - w0); end
    endtask

    task automatic test_rmw();
        int lat; logic [31:0] rd; logic e; int w0, r0;
        ram[1] = 32'h1122_3344;
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(SB, 32'h0000_0006, 32'h1234_56AA, lat, rd, e);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sb_latency got=%0d exp=4", lat); end
        checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin errors++; $display("FAIL sb_strobes wr=%0d rd=%0d exp=1/1", wr_cnt - w0, rd_cnt - r0); end
        checks++; if (last_wa !== 10'd1 || last_wd !== 32'h11AA_3344) begin errors++; $display("FAIL sb_write addr=%0d data=%h exp=1/11aa3344", last_wa, last_wd); end
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_resp err=%b rdata=%h exp=0/0", e, rd); end
        do_req(SH, 32'h0000_0004, 32'hCAFE_BEEF, lat, rd, e);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sh_latency got=%0d exp=4", lat); end
        checks++; if (ram[1] !== 32'h11AA_BEEF) begin errors++; $display("FAIL sh_ram got=%h exp=11aabeef", ram[1]); end
        do_req(SH, 32'h0000_0006, 32'h0000_5566, lat, rd, e);
        checks++; if (ram[1] !== 32'h5566_BEEF) begin errors++; $display("FAIL sh_hi_ram got=%h exp=5566beef", ram[1]); end
        do_req(SB, 32'h0000_0004, 32'h0000_0011, lat, rd, e);
        checks++; if (ram[1] !== 32'h5566_BE11) begin errors++; $display("FAIL sb_lane0_ram got=%h exp=5566be11", ram[1]); end
    endtask

    task automatic test_misalign();
        logic [2:0]  c [5] = '{LH, LW, SW, SH, LHU};
        logic [31:0] a [5] = '{32'h001, 32'h002, 32'h003, 32'h005, 32'h003};
        int lat; logic [31:0] rd; logic e; int s0;
        s0 = wr_cnt + rd_cnt;
        for (int i = 0; i < 5; i++) begin
            do_req(c[i], a[i], 32'h5A5A_5A5A, lat, rd, e);
            checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign%0d_resp err=%b rdata=%h exp=1/0", i, e, rd); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL misalign%0d_latency got=%0d exp=1", i, lat); end
        end
        checks++; if (wr_cnt + rd_cnt !== s0) begin errors++; $display("FAIL misalign_mem_en strobes=%0d exp=0", wr_cnt + rd_cnt - s0); end
    endtask

    task automatic test_backpressure();
        int a0; bit seen;
        ram[2] = 32'h80FF_7F01;
        a0 = acc_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = LW; req_addr = 32'h008; req_wdata = '0; resp_ready = 1'b0;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (resp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_resp_timeout got=none exp=resp_valid"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h80FF_7F01 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d valid=%b rdata=%h ready=%b exp=1/80ff7f01/0", i, resp_valid, resp_rdata, req_ready); end
            @(posedge clk); #1;
        end
        checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL bp_accepts_hold got=%0d exp=1", acc_cnt - a0); end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || acc_cnt - a0 !== 1) begin errors++; $display("FAIL bp_handshake valid=%b ready=%b acc=%0d exp=0/1/1", resp_valid, req_ready, acc_cnt - a0); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (acc_cnt - a0 !== 2 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept acc=%0d ready=%b exp=2/0", acc_cnt - a0, req_ready); end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (resp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!seen || resp_rdata !== 32'h80FF_7F01) begin errors++; $display("FAIL bp_second_resp seen=%b rdata=%h exp=1/80ff7f01", seen, resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w0;
        ram[1] = 32'h11AA_BEEF;
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = SB; req_addr = 32'h004; req_wdata = 32'h55; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL rstmid_ctl ready=%b valid=%b err=%b exp=1/0/0", req_ready, resp_valid, resp_err); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_outputs en=%b we=%b addr=%h wdata=%h rdata=%h exp=0", mem_en, mem_we, mem_addr, mem_wdata, resp_rdata); end
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wr_cnt !== w0 || ram[1] !== 32'h11AA_BEEF) begin errors++; $display("FAIL rstmid_no_write wr=%0d ram=%h exp=0/11aabeef", wr_cnt - w0, ram[1]); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle ready=%b valid=%b exp=1/0", req_ready, resp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        mem_rdata = 32'h0;
        test_reset();
        test_sw();
        checks++; if (ram[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_ram got=%h exp=deadbeef", ram[2]); end
        test_loads();
        test_rmw();
        test_misalign();
        test_backpressure();
        test_reset_mid();
        checks++; if (illegal_cnt !== 0) begin errors++; $display("FAIL strobe_state_rules got=%0d exp=0", illegal_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
